// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl: PLL divider-profile loader with reset/lock/retry sequencing
module pll_reconfig_ctrl #(
  parameter int          NUM_PROFILES    = 4,
  parameter logic [47:0] IDIV_TABLE      = 48'h0,
  parameter logic [47:0] FBDIV_TABLE     = 48'h0,
  parameter logic [47:0] ODIV_TABLE      = 48'h0,
  parameter int          DEFAULT_PROFILE = 0,
  parameter int          RST_HOLD        = 27,
  parameter int          LOCK_TIMEOUT    = 2700,
  parameter int          LOCK_FILT       = 16,
  parameter int          MAX_RETRY       = 3
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       req,
  input  logic [2:0] profile_sel,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] idsel,
  output logic [5:0] fbdsel,
  output logic [5:0] odsel,
  output logic       ready,
  output logic       busy,
  output logic       fail,
  output logic       err,
  output logic [2:0] cur_profile
);
  localparam int HW = $clog2(RST_HOLD + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int FW = $clog2(LOCK_FILT + 1);
  localparam int AW = $clog2(MAX_RETRY + 1);
  typedef enum logic [2:0] {HOLD, WAIT_LOCK, FILTER, LOCKED, FAIL} state_t;
  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] to_q, to_d, to_inc;
  logic [FW-1:0] filt_q, filt_d;
  logic [AW-1:0] att_q, att_d, att_inc;
  logic          s1_q, s2_q, lock_s;
  logic          ok, load, err_d;
  assign lock_s  = s2_q;
  assign ok      = 32'(profile_sel) < NUM_PROFILES;
  assign to_inc  = to_q + TW'(1);
  assign att_inc = att_q + AW'(1);
  // next-state: hold/lock/filter/timeout sequencing and request acceptance
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    to_d    = to_q;
    filt_d  = filt_q;
    att_d   = att_q;
    load    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      HOLD: begin
        hold_d = hold_q + HW'(1);
        if (hold_q == HW'(RST_HOLD - 1)) begin
          state_d = WAIT_LOCK;
          hold_d  = '0;
          to_d    = '0;
          filt_d  = '0;
        end
      end
      WAIT_LOCK, FILTER: begin
        to_d   = to_inc;
        filt_d = lock_s ? filt_q + FW'(1) : '0;
        if (lock_s && filt_d == FW'(LOCK_FILT)) begin
          state_d = LOCKED;
          att_d   = '0;
        end else if (to_inc == TW'(LOCK_TIMEOUT)) begin
          att_d   = att_inc;
          hold_d  = '0;
          state_d = (att_inc < AW'(MAX_RETRY)) ? HOLD : FAIL;
        end else state_d = lock_s ? FILTER : WAIT_LOCK;
      end
      LOCKED: begin
        err_d = req && !ok;
        load  = req && ok;
        if (!lock_s) begin
          state_d = HOLD;
          hold_d  = '0;
          att_d   = '0;
        end
      end
      FAIL: begin
        err_d = req && !ok;
        load  = req && ok;
      end
      default: state_d = HOLD;
    endcase
    if (load) begin
      state_d = HOLD;
      hold_d  = '0;
      att_d   = '0;
    end
  end
  // state, lock synchroniser and registered outputs derived from the next state
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q     <= HOLD;
      hold_q      <= '0;
      to_q        <= '0;
      filt_q      <= '0;
      att_q       <= '0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      pll_reset   <= 1'b1;
      busy        <= 1'b1;
      ready       <= 1'b0;
      fail        <= 1'b0;
      err         <= 1'b0;
      cur_profile <= 3'(DEFAULT_PROFILE);
      idsel       <= IDIV_TABLE[6*DEFAULT_PROFILE +: 6];
      fbdsel      <= FBDIV_TABLE[6*DEFAULT_PROFILE +: 6];
      odsel       <= ODIV_TABLE[6*DEFAULT_PROFILE +: 6];
    end else begin
      s1_q      <= pll_lock;
      s2_q      <= s1_q;
      state_q   <= state_d;
      hold_q    <= hold_d;
      to_q      <= to_d;
      filt_q    <= filt_d;
      att_q     <= att_d;
      pll_reset <= state_d == HOLD || state_d == FAIL;
      busy      <= state_d == HOLD || state_d == WAIT_LOCK || state_d == FILTER;
      ready     <= state_d == LOCKED;
      fail      <= state_d == FAIL;
      err       <= err_d;
      if (load) begin
        cur_profile <= profile_sel;
        idsel       <= IDIV_TABLE[6*int'(profile_sel) +: 6];
        fbdsel      <= FBDIV_TABLE[6*int'(profile_sel) +: 6];
        odsel       <= ODIV_TABLE[6*int'(profile_sel) +: 6];
      end
    end
  end
endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// tb_pll_reconfig_ctrl: scoreboard bench with a phase-level reference model
module tb_pll_reconfig_ctrl;
  localparam int NP = 4, RH = 4, LT = 50, LF = 3, MR = 2, DEF = 0;
  localparam logic [47:0] IT = 48'hFEDCBA987654;
  localparam logic [47:0] FT = 48'h13579BDF2468;
  localparam logic [47:0] OT = 48'h0F1E2D3C4B5A;
  logic clk = 0, rst = 0, req = 0, lock = 0;
  logic [2:0] sel = 0;
  logic pll_reset, ready, busy, fail, err;
  logic [5:0] idsel, fbdsel, odsel;
  logic [2:0] cur_profile;
  int errors = 0, checks = 0;
  logic [25:0] exp_q[$];
  // model: ph 0=in reset pulse, 1=seeking lock, 2=locked, 3=given up
  int ph, hold, tmr, run, att, prof;
  bit m_err, l1, l2;

  always #5 clk = ~clk;

  pll_reconfig_ctrl #(
    .NUM_PROFILES(NP), .IDIV_TABLE(IT), .FBDIV_TABLE(FT), .ODIV_TABLE(OT),
    .DEFAULT_PROFILE(DEF), .RST_HOLD(RH), .LOCK_TIMEOUT(LT), .LOCK_FILT(LF), .MAX_RETRY(MR)
  ) dut (
    .clkin(clk), .reset(rst), .req(req), .profile_sel(sel), .pll_lock(lock),
    .pll_reset(pll_reset), .idsel(idsel), .fbdsel(fbdsel), .odsel(odsel),
    .ready(ready), .busy(busy), .fail(fail), .err(err), .cur_profile(cur_profile)
  );

  function automatic logic [5:0] code(input logic [47:0] t, input int p);
    logic [47:0] s;
    s = t >> (6 * p);
    return s[5:0];
  endfunction

  task automatic model_step();
    bit ls;
    bit ok;
    if (rst) begin
      ph = 0; hold = 0; tmr = 0; run = 0; att = 0; prof = DEF; m_err = 0; l1 = 0; l2 = 0;
    end else begin
      ls = l2; l2 = l1; l1 = lock;
      m_err = 0;
      ok = int'(sel) < NP;
      if (ph == 0) begin
        hold++;
        if (hold == RH) begin ph = 1; tmr = 0; run = 0; end
      end else if (ph == 1) begin
        tmr++;
        run = ls ? run + 1 : 0;
        if (run == LF) begin ph = 2; att = 0; end
        else if (tmr == LT) begin
          att++;
          hold = 0;
          ph = (att < MR) ? 0 : 3;
        end
      end else begin
        if (req && !ok) m_err = 1;
        if (req && ok) begin prof = int'(sel); ph = 0; hold = 0; att = 0; end
        else if (ph == 2 && !ls) begin ph = 0; hold = 0; att = 0; end
      end
    end
    exp_q.push_back({ph == 0 || ph == 3, ph <= 1, ph == 2, ph == 3, m_err, 3'(prof),
                     code(IT, prof), code(FT, prof), code(OT, prof)});
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    logic [25:0] e, a;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {pll_reset, busy, ready, fail, err, cur_profile, idsel, fbdsel, odsel};
      checks++;
      if (a !== e)
        begin
          errors++;
          $display("FAIL outputs t=%0t got rst/busy/rdy/fail/err=%b%b%b%b%b prof=%0d div=%h,%h,%h exp %b%b%b%b%b prof=%0d div=%h,%h,%h",
                   $time, a[25], a[24], a[23], a[22], a[21], a[20:18], a[17:12], a[11:6], a[5:0],
                   e[25], e[24], e[23], e[22], e[21], e[20:18], e[17:12], e[11:6], e[5:0]);
        end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_req(input int s);
    req = 1; sel = 3'(s);
    @(negedge clk);
    req = 0;
  endtask

  function automatic logic sig(input int w);
    return w == 0 ? ready : w == 1 ? fail : !pll_reset;
  endfunction

  task automatic wait_for(input int w, input int budget, input string name);
    int n = 0;
    while (sig(w) !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    checks++;
    if (sig(w) !== 1'b1) begin
      errors++;
      $display("FAIL %s: event not seen within %0d cycles (got %b, required 1)", name, budget, sig(w));
    end
  endtask

  initial begin
    #1 rst = 1; lock = 1;
    cycles(3);
    rst = 0;
    wait_for(0, 20, "powerup_ready");
    cycles(3);
    pulse_req(2);
    pulse_req(3);
    wait_for(0, 40, "switch_ready");
    cycles(2);
    pulse_req(5);
    cycles(3);
    lock = 0;
    cycles(3);
    lock = 1;
    wait_for(0, 60, "relock_ready");
    lock = 0;
    wait_for(1, 200, "retry_fail");
    cycles(4);
    pulse_req(6);
    cycles(2);
    lock = 1;
    pulse_req(1);
    wait_for(0, 60, "recover_ready");
    lock = 0;
    pulse_req(3);
    wait_for(2, 20, "glitch_wait_lock");
    cycles(5);
    lock = 1;
    cycles(2);
    lock = 0;
    cycles(15);
    lock = 1;
    wait_for(0, 120, "glitch_then_ready");
    pulse_req(0);
    cycles(6);
    rst = 1;
    cycles(2);
    rst = 0;
    wait_for(0, 40, "midreset_ready");
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) lock = ~lock;
      req = $urandom_range(0, 11) == 0;
      sel = 3'($urandom_range(0, 7));
      rst = $urandom_range(0, 599) == 0;
      @(negedge clk);
    end
    req = 0; rst = 0; lock = 1;
    wait_for(0, 400, "final_ready");
    cycles(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
